// File: rtl/comms_frame_controller.sv
// comms_frame_controller
//   Host-side bus master for the Titan core array. Collects 8-byte command frames from a byte
//   link, drives one instruction/address/value bus cycle to all cores, and for READ/STREAM
//   returns the captured 32-bit result to the host as 4 bytes, MSB first.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   rx_data_i/valid_i/ready_o  host byte stream into the controller
//   tx_data_o/valid_o/ready_i  response bytes back to the host
//   instruction_o/address_o/value_o  broadcast bus to every core_interface
//   result_i                 OR-combined core results (READ)
//   stream_i                 bound output core stream (STREAM)
//   busy_o                   low only when idle in RX with no partial frame
module comms_frame_controller #(
    parameter int unsigned INSTRUCTION_WIDTH = 8,
    parameter int unsigned ADDRESS_WIDTH     = 24,
    parameter int unsigned VALUE_WIDTH       = 32,
    parameter logic [7:0]  IDLE_INSTRUCTION  = 8'h00,
    parameter logic [7:0]  OP_READ           = 8'h02,
    parameter logic [7:0]  OP_STREAM         = 8'h03,
    parameter int unsigned RESULT_LATENCY    = 1,
    parameter int unsigned TIMEOUT_CYCLES    = 100000
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [7:0]                   rx_data_i,
    input  logic                         rx_valid_i,
    output logic                         rx_ready_o,
    output logic [7:0]                   tx_data_o,
    output logic                         tx_valid_o,
    input  logic                         tx_ready_i,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_o,
    output logic [ADDRESS_WIDTH-1:0]     address_o,
    output logic [VALUE_WIDTH-1:0]       value_o,
    input  logic [VALUE_WIDTH-1:0]       result_i,
    input  logic [VALUE_WIDTH-1:0]       stream_i,
    output logic                         busy_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StRx, StIssue, StWait, StTx} state_e;

    state_e        state_q, state_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [63:0]   frame_q, frame_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]    lat_cnt_q, lat_cnt_d;
    logic [1:0]    tx_idx_q, tx_idx_d;
    logic [31:0]   resp_q, resp_d;
    logic [7:0]    instr_q, instr_d;
    logic [23:0]   addr_q, addr_d;
    logic [31:0]   value_q, value_d;
    logic          rx_ready_q, rx_ready_d;
    logic          rx_fire;
    logic [7:0]    opcode;

    assign rx_fire = rx_valid_i && rx_ready_q;
    assign opcode  = frame_q[63:56];

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        frame_d    = frame_q;
        to_cnt_d   = to_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        tx_idx_d   = tx_idx_q;
        resp_d     = resp_q;
        instr_d    = IDLE_INSTRUCTION;
        addr_d     = addr_q;
        value_d    = value_q;

        unique case (state_q)
            StRx: begin
                if (rx_fire) begin
                    frame_d    = {frame_q[55:0], rx_data_i};
                    to_cnt_d   = '0;
                    byte_cnt_d = byte_cnt_q + 3'd1;  // wraps to 0 after byte 7
                    if (byte_cnt_q == 3'd7) begin
                        state_d = StIssue;
                    end
                end else if (byte_cnt_q != 3'd0) begin
                    if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        byte_cnt_d = '0;
                        to_cnt_d   = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
                end
            end
            StIssue: begin
                instr_d   = frame_q[63:56];
                addr_d    = frame_q[55:32];
                value_d   = frame_q[31:0];
                lat_cnt_d = 4'd1;
                state_d   = (opcode == OP_READ || opcode == OP_STREAM) ? StWait : StRx;
            end
            StWait: begin
                // lat_cnt_q holds the number of edges since issue that this edge completes
                if (lat_cnt_q == 4'(RESULT_LATENCY)) begin
                    resp_d   = (opcode == OP_STREAM) ? stream_i : result_i;
                    tx_idx_d = '0;
                    state_d  = StTx;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            StTx: begin
                if (tx_ready_i) begin
                    tx_idx_d = tx_idx_q + 2'd1;
                    if (tx_idx_q == 2'd3) begin
                        state_d = StRx;
                    end
                end
            end
            default: state_d = StRx;
        endcase
    end

    // Registered so there is no rx_valid_i -> rx_ready_o path; also yields the one dead
    // cycle after an issue or a response before the next frame is accepted.
    assign rx_ready_d = (state_q == StRx) && (state_d == StRx);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StRx;
            byte_cnt_q <= '0;
            frame_q    <= '0;
            to_cnt_q   <= '0;
            lat_cnt_q  <= '0;
            tx_idx_q   <= '0;
            resp_q     <= '0;
            instr_q    <= IDLE_INSTRUCTION;
            addr_q     <= '0;
            value_q    <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            frame_q    <= frame_d;
            to_cnt_q   <= to_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            tx_idx_q   <= tx_idx_d;
            resp_q     <= resp_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            value_q    <= value_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    always_comb begin
        tx_data_o = 8'h00;
        if (state_q == StTx) begin
            unique case (tx_idx_q)
                2'd0:    tx_data_o = resp_q[31:24];
                2'd1:    tx_data_o = resp_q[23:16];
                2'd2:    tx_data_o = resp_q[15:8];
                default: tx_data_o = resp_q[7:0];
            endcase
        end
    end

    assign tx_valid_o    = (state_q == StTx);
    assign rx_ready_o    = rx_ready_q;
    assign instruction_o = instr_q;
    assign address_o     = addr_q;
    assign value_o       = value_q;
    assign busy_o        = !((state_q == StRx) && (byte_cnt_q == 3'd0));

endmodule

// File: tb/tb_comms_frame_controller.sv
module tb_comms_frame_controller;

    localparam logic [7:0] IDLE = 8'h00;
    localparam logic [7:0] WR   = 8'h01;
    localparam logic [7:0] RD   = 8'h02;
    localparam logic [7:0] ST   = 8'h03;
    localparam int T   = 16;
    localparam int LAT = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  instruction_o;
    logic [23:0] address_o;
    logic [31:0] value_o;
    logic [31:0] result_i;
    logic [31:0] stream_i;
    logic        busy_o;

    logic [31:0] stream_val;
    logic        stream_mode;
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    int          tx_seen = 0;
    int          issue_neg_cyc = 0;

    typedef struct {
        logic [7:0]  op;
        logic [23:0] a;
        logic [31:0] v;
    } bus_t;
    bus_t issues[$];

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        logic [31:0] value;
        logic [31:0] result;
        logic [31:0] stream;
        bit          has_resp;
        logic [31:0] resp;
    } vec_t;
    vec_t vecs[6];

    comms_frame_controller #(
        .IDLE_INSTRUCTION(IDLE),
        .OP_READ         (RD),
        .OP_STREAM       (ST),
        .RESULT_LATENCY  (LAT),
        .TIMEOUT_CYCLES  (T)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .rx_ready_o   (rx_ready_o),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .instruction_o(instruction_o),
        .address_o    (address_o),
        .value_o      (value_o),
        .result_i     (result_i),
        .stream_i     (stream_i),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] sfun(input int k);
        return 32'hA5C30000 ^ (32'(k) * 32'h01030507);
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;
    assign stream_i = stream_mode ? sfun(cyc) : stream_val;

    // Bus and tx monitor, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (rst_ni && instruction_o != IDLE) begin
            issues.push_back('{instruction_o, address_o, value_o});
            issue_neg_cyc = cyc;
        end
        if (tx_valid_o) tx_seen++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!rx_ready_o) begin
            chk("rx_ready wait expired", 0, 1);
        end else begin
            @(negedge clk_i);
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [23:0] a, input logic [31:0] v);
        logic [63:0] f;
        f = {op, a, v};
        for (int i = 0; i < 8; i++) send_byte(f[63-8*i -: 8]);
    endtask

    task automatic recv_word(input int stall, output logic [31:0] w);
        logic [7:0] held;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            while (!tx_valid_o && n < 100) begin
                @(negedge clk_i);
                n++;
            end
            if (!tx_valid_o) begin
                chk("tx_valid wait expired", 0, 1);
                return;
            end
            held = tx_data_o;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk_i);
                chk("tx_data stable in stall", tx_data_o, held);
                chk("tx_valid held in stall", tx_valid_o, 1);
                chk("rx_ready low during tx", rx_ready_o, 0);
            end
            tx_ready_i = 1'b1;
            w = {w[23:0], tx_data_o};
            @(negedge clk_i);
            tx_ready_i = 1'b0;
        end
    endtask

    task automatic chk_one_issue(input string name, input logic [7:0] op, input logic [23:0] a,
                                 input logic [31:0] v);
        chk({name, " issue count"}, issues.size(), 1);
        if (issues.size() >= 1)
            chk({name, " bus fields"}, {issues[0].op, issues[0].a, issues[0].v}, {op, a, v});
    endtask

    initial begin
        logic [31:0] w;
        int          txb;

        vecs[0] = '{WR,   24'h000010, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[1] = '{RD,   24'h000011, 32'h00000000, 32'h12345678, 32'h0,        1'b1, 32'h12345678};
        vecs[2] = '{ST,   24'h000020, 32'h00000000, 32'h0BADBEEF, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
        vecs[3] = '{RD,   24'hABCDEF, 32'h55AA55AA, 32'h89ABCDEF, 32'h11111111, 1'b1, 32'h89ABCDEF};
        vecs[4] = '{8'h7E, 24'h123456, 32'h00000000, 32'h77777777, 32'h66666666, 1'b0, 32'h0};
        vecs[5] = '{WR,   24'hFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 32'h0};

        rst_ni = 1'b1; rx_data_i = '0; rx_valid_i = 1'b0; tx_ready_i = 1'b0;
        result_i = '0; stream_val = '0; stream_mode = 1'b0;

        // Reset state
        #2 rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("reset rx_ready", rx_ready_o, 0);
        chk("reset instruction", instruction_o, IDLE);
        chk("reset address", address_o, 0);
        chk("reset value", value_o, 0);
        chk("reset tx_valid", tx_valid_o, 0);
        chk("reset tx_data", tx_data_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle rx_ready", rx_ready_o, 1);
        chk("idle busy", busy_o, 0);

        // Issue latency: last byte -> bus 1 edge later -> rx_ready 1 edge after that
        issues.delete();
        send_frame(WR, 24'h000001, 32'h00000001);
        chk("issue cycle instruction idle", instruction_o, IDLE);
        chk("issue cycle rx_ready", rx_ready_o, 0);
        chk("issue cycle busy", busy_o, 1);
        @(negedge clk_i);
        chk("bus cycle instruction", instruction_o, WR);
        chk("bus cycle rx_ready", rx_ready_o, 0);
        @(negedge clk_i);
        chk("after bus instruction idle", instruction_o, IDLE);
        chk("after bus rx_ready", rx_ready_o, 1);
        chk("after bus address hold", address_o, 24'h000001);
        send_frame(WR, 24'h000002, 32'h00000002);
        repeat (3) @(negedge clk_i);
        chk("back-to-back issue count", issues.size(), 2);

        // Table of single-frame commands
        for (int i = 0; i < 6; i++) begin
            issues.delete();
            result_i   = vecs[i].result;
            stream_val = vecs[i].stream;
            txb        = tx_seen;
            send_frame(vecs[i].op, vecs[i].addr, vecs[i].value);
            if (vecs[i].has_resp) begin
                recv_word(0, w);
                chk($sformatf("vec%0d response", i), w, vecs[i].resp);
            end else begin
                repeat (8) @(negedge clk_i);
                chk($sformatf("vec%0d no tx", i), tx_seen - txb, 0);
            end
            repeat (2) @(negedge clk_i);
            chk_one_issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].value);
            chk($sformatf("vec%0d value hold", i), value_o, vecs[i].value);
        end

        // STREAM with a changing stream_i: sampled LAT edges after the issue edge
        issues.delete();
        result_i    = 32'hFFFF0000;
        stream_mode = 1'b1;
        send_frame(ST, 24'h000030, 32'h0);
        recv_word(0, w);
        chk_one_issue("stream", ST, 24'h000030, 32'h0);
        chk("stream latency sample", w, sfun(issue_neg_cyc + LAT - 1));
        stream_mode = 1'b0;

        // READ with tx back-pressure
        issues.delete();
        result_i = 32'h0F1E2D3C;
        send_frame(RD, 24'h000040, 32'h0);
        recv_word(5, w);
        chk("backpressure response", w, 32'h0F1E2D3C);
        @(negedge clk_i);
        chk("rx_ready after response", rx_ready_o, 1);

        // Timeout: partial frame dropped after T idle cycles
        issues.delete();
        send_byte(WR); send_byte(8'hAA); send_byte(8'hBB);
        repeat (T - 1) @(negedge clk_i);
        chk("partial frame before timeout busy", busy_o, 1);
        @(negedge clk_i);
        chk("partial frame after timeout busy", busy_o, 0);
        send_frame(WR, 24'h000044, 32'h01020304);
        repeat (3) @(negedge clk_i);
        chk_one_issue("after timeout", WR, 24'h000044, 32'h01020304);

        // Gap shorter than the timeout keeps the frame
        issues.delete();
        send_byte(WR); send_byte(8'h00); send_byte(8'h00);
        repeat (T - 2) @(negedge clk_i);
        send_byte(8'h55); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        repeat (3) @(negedge clk_i);
        chk_one_issue("short gap", WR, 24'h000055, 32'h11223344);

        // Reset after byte 5 of a frame
        issues.delete();
        send_byte(WR); send_byte(8'h00); send_byte(8'h00); send_byte(8'h99); send_byte(8'h12);
        rst_ni = 1'b0;
        #1;
        chk("mid-frame reset rx_ready", rx_ready_o, 0);
        chk("mid-frame reset instruction", instruction_o, IDLE);
        chk("mid-frame reset address", address_o, 0);
        chk("mid-frame reset value", value_o, 0);
        chk("mid-frame reset tx_valid", tx_valid_o, 0);
        chk("mid-frame reset busy", busy_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("no issue after reset", issues.size(), 0);
        send_frame(WR, 24'h000077, 32'hA1B2C3D4);
        repeat (3) @(negedge clk_i);
        chk_one_issue("after reset", WR, 24'h000077, 32'hA1B2C3D4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
